// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n items; never zero so single-item ports stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  int            idx;
  logic [SW-1:0] idx_sw;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    idx_sw     = '0;
    for (int k = 0; k < N; k++) begin
      // Wrap by subtraction; ptr is always below N so one step suffices.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_sw = idx[SW-1:0];
      if (!any && req[idx_sw]) begin
        any                = 1'b1;
        gnt_idx            = idx_sw;
        gnt_onehot[idx_sw] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered valid/ready stream multiplexer with external-select or
// round-robin channel choice feeding one output register.
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  parameter int  MODE  = MODE_SEL,
  localparam int SW    = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW-1:0]         sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SW-1:0]         grant_idx
);

  logic             load;
  logic             eligible;
  logic             take;
  logic [N_CH-1:0]  cand_onehot;
  logic [SW-1:0]    cand_idx;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] masked [N_CH];

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SW-1:0]    grant_idx_reg;

  assign load = !out_valid_reg || out_ready;
  // Gated by rst so no producer sees a handshake that reset is about to discard.
  assign take     = load && eligible && !rst;
  assign in_ready = take ? cand_onehot : '0;

  if (MODE == MODE_RR) begin : g_rr
    logic [SW-1:0] rr_ptr_reg;
    logic [SW-1:0] rr_ptr_next;
    logic          unused_sel;

    assign unused_sel = ^sel;

    rr_arbiter #(
      .N  (N_CH),
      .SW (SW)
    ) u_arb (
      .req        (in_valid),
      .ptr        (rr_ptr_reg),
      .gnt_onehot (cand_onehot),
      .gnt_idx    (cand_idx),
      .any        (eligible)
    );

    always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (take) begin
        rr_ptr_next = (cand_idx == SW'(N_CH - 1)) ? '0 : cand_idx + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rr_ptr_reg <= '0;
      end else begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end else begin : g_sel
    // An out-of-range sel matches no channel and therefore grants nothing.
    always_comb begin
      cand_onehot = '0;
      cand_idx    = sel;
      eligible    = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          cand_onehot[i] = 1'b1;
          eligible       = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
    assign masked[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{cand_onehot[gi]}};
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      mux_data = mux_data | masked[i];
    end
  end

  // Data and index keep their last value after a drain; only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      grant_idx_reg <= '0;
    end else if (load) begin
      out_valid_reg <= eligible;
      if (eligible) begin
        out_data_reg  <= mux_data;
        grant_idx_reg <= cand_idx;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench: one select-mode and one round-robin instance against a behavioural model.
module tb_stream_mux_n;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [SW-1:0] sel;

  logic [N*W-1:0] in_data_s, in_data_r;
  logic [N-1:0]   in_valid_s, in_valid_r;
  logic [N-1:0]   in_ready_s, in_ready_r;
  logic [W-1:0]   out_data_s, out_data_r;
  logic           out_valid_s, out_valid_r;
  logic           out_ready_s, out_ready_r;
  logic [SW-1:0]  grant_idx_s, grant_idx_r;
  logic [SW-1:0]  unused_sel_r;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic         ms_valid, mr_valid;
  logic [W-1:0] ms_data, mr_data;
  int           ms_gidx, mr_gidx;
  int           mr_ptr;

  assign unused_sel_r = ~sel;

  stream_mux_n #(.N_CH(N), .WIDTH(W), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .sel(sel),
    .in_data(in_data_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .grant_idx(grant_idx_s)
  );

  stream_mux_n #(.N_CH(N), .WIDTH(W), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .sel(unused_sel_r),
    .in_data(in_data_r), .in_valid(in_valid_r), .in_ready(in_ready_r),
    .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready_r),
    .grant_idx(grant_idx_r)
  );

  function automatic logic [N-1:0] exp_rdy_s();
    logic [N-1:0] r;
    r = '0;
    if (!rst && (!ms_valid || out_ready_s) && int'(sel) < N && in_valid_s[sel]) r[sel] = 1'b1;
    return r;
  endfunction

  // First valid channel scanning from the pointer, or -1.
  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      if (in_valid_r[(mr_ptr + k) % N]) return (mr_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy_r();
    logic [N-1:0] r;
    int p;
    r = '0;
    p = rr_pick();
    if (!rst && (!mr_valid || out_ready_r) && p >= 0) r[p] = 1'b1;
    return r;
  endfunction

  // Advance one clock and apply the transfer rules to the model.
  task automatic tick();
    logic [N-1:0] rs, rr;
    int p;
    logic [W-1:0] ds, dr;
    rs = exp_rdy_s();
    rr = exp_rdy_r();
    p  = rr_pick();
    ds = in_data_s[int'(sel)*W +: W];
    dr = (p >= 0) ? in_data_r[p*W +: W] : '0;
    @(posedge clk);
    if (rst) begin
      ms_valid = 1'b0; ms_data = '0; ms_gidx = 0;
      mr_valid = 1'b0; mr_data = '0; mr_gidx = 0; mr_ptr = 0;
    end else begin
      if (!ms_valid || out_ready_s) begin
        ms_valid = |rs;
        if (|rs) begin
          ms_data = ds;
          ms_gidx = int'(sel);
          $display("xfer sel ch=%0d data=%02h", ms_gidx, ms_data);
        end
      end
      if (!mr_valid || out_ready_r) begin
        mr_valid = |rr;
        if (|rr) begin
          mr_data = dr;
          mr_gidx = p;
          mr_ptr  = (p + 1) % N;
          $display("xfer rr  ch=%0d data=%02h", mr_gidx, mr_data);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_s = '1; in_valid_r = '1; sel = 2'd2;
    out_ready_s = 1'b1; out_ready_r = 1'b1;
    in_data_s = $urandom; in_data_r = $urandom;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks += 6;
      if (in_ready_s !== 4'b0) begin failures++; $display("FAIL reset_rdy_s: got %b want 0000", in_ready_s); end
      if (in_ready_r !== 4'b0) begin failures++; $display("FAIL reset_rdy_r: got %b want 0000", in_ready_r); end
      if (out_valid_s !== 1'b0 || out_valid_r !== 1'b0) begin
        failures++; $display("FAIL reset_valid: got %b/%b want 0/0", out_valid_s, out_valid_r);
      end
      if (out_data_s !== 8'h00 || out_data_r !== 8'h00) begin
        failures++; $display("FAIL reset_data: got %h/%h want 00/00", out_data_s, out_data_r);
      end
      if (grant_idx_s !== 2'd0) begin failures++; $display("FAIL reset_gidx_s: got %0d want 0", grant_idx_s); end
      if (grant_idx_r !== 2'd0) begin failures++; $display("FAIL reset_gidx_r: got %0d want 0", grant_idx_r); end
    end
    rst = 1'b0;
    in_valid_s = '0; in_valid_r = '0;
    tick();
  endtask

  task automatic test_sel_basic();
    in_data_s = 32'h00A5_0000; in_valid_s = 4'b0100; sel = 2'd2; out_ready_s = 1'b1;
    #1;
    checks++;
    if (in_ready_s !== 4'b0100) begin failures++; $display("FAIL sel_rdy: got %b want 0100", in_ready_s); end
    tick();
    checks += 3;
    if (out_data_s !== 8'hA5) begin failures++; $display("FAIL sel_data: got %h want a5", out_data_s); end
    if (out_valid_s !== 1'b1) begin failures++; $display("FAIL sel_valid: got %b want 1", out_valid_s); end
    if (grant_idx_s !== 2'd2) begin failures++; $display("FAIL sel_gidx: got %0d want 2", grant_idx_s); end
    sel = 2'd3;
    #1;
    checks++;
    if (in_ready_s !== 4'b0000) begin failures++; $display("FAIL sel_norq_rdy: got %b want 0000", in_ready_s); end
    tick();
    checks += 2;
    if (out_valid_s !== 1'b0) begin failures++; $display("FAIL sel_drain_valid: got %b want 0", out_valid_s); end
    if (out_data_s !== 8'hA5) begin failures++; $display("FAIL sel_drain_hold: got %h want a5", out_data_s); end
  endtask

  task automatic test_backpressure();
    sel = 2'd1; in_valid_s = 4'b0010; in_data_s = 32'h0000_3C00; out_ready_s = 1'b1;
    tick();
    checks++;
    if (out_data_s !== 8'h3C) begin failures++; $display("FAIL bp_load: got %h want 3c", out_data_s); end
    out_ready_s = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sel = SW'($urandom_range(0, 3)); in_valid_s = '1; in_data_s = $urandom;
      #1;
      checks++;
      if (in_ready_s !== 4'b0000) begin failures++; $display("FAIL bp_rdy: got %b want 0000", in_ready_s); end
      tick();
      checks += 2;
      if (out_data_s !== 8'h3C || out_valid_s !== 1'b1) begin
        failures++; $display("FAIL bp_hold: got %h/%b want 3c/1", out_data_s, out_valid_s);
      end
      if (grant_idx_s !== 2'd1) begin failures++; $display("FAIL bp_gidx: got %0d want 1", grant_idx_s); end
    end
    out_ready_s = 1'b1; sel = 2'd0; in_valid_s = 4'b0001; in_data_s = 32'h0000_005A;
    #1;
    checks++;
    if (in_ready_s !== 4'b0001) begin failures++; $display("FAIL bp_release_rdy: got %b want 0001", in_ready_s); end
    tick();
    checks++;
    if (out_data_s !== 8'h5A || grant_idx_s !== 2'd0) begin
      failures++; $display("FAIL bp_next: got %h/%0d want 5a/0", out_data_s, grant_idx_s);
    end
    in_valid_s = '0;
    tick();
  endtask

  task automatic test_rr_all();
    int seq_a [5];
    int seq_b [4];
    seq_a = '{0, 1, 2, 3, 0};
    seq_b = '{2, 3, 0, 2};
    in_data_r = 32'h1312_1110; in_valid_r = 4'b1111; out_ready_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready_r !== 4'(1 << seq_a[k])) begin
        failures++; $display("FAIL rr_all_rdy[%0d]: got %b want one-hot %0d", k, in_ready_r, seq_a[k]);
      end
      tick();
      checks++;
      if (int'(grant_idx_r) != seq_a[k] || out_data_r !== 8'(8'h10 + seq_a[k]) || out_valid_r !== 1'b1) begin
        failures++; $display("FAIL rr_all[%0d]: got ch%0d %h want ch%0d", k, grant_idx_r, out_data_r, seq_a[k]);
      end
    end
    in_valid_r = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (int'(grant_idx_r) != seq_b[k] || out_data_r !== 8'(8'h10 + seq_b[k])) begin
        failures++; $display("FAIL rr_skip[%0d]: got ch%0d %h want ch%0d", k, grant_idx_r, out_data_r, seq_b[k]);
      end
    end
    in_valid_r = '0;
    tick();
  endtask

  task automatic test_rr_wrap();
    int seq [3];
    seq = '{3, 0, 3};
    out_ready_r = 1'b1;
    in_valid_r = 4'b0100;
    tick();
    checks++;
    if (grant_idx_r !== 2'd2) begin failures++; $display("FAIL wrap_setup: got %0d want 2", grant_idx_r); end
    in_valid_r = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (int'(grant_idx_r) != seq[k]) begin
        failures++; $display("FAIL wrap[%0d]: got ch%0d want ch%0d", k, grant_idx_r, seq[k]);
      end
    end
    in_valid_r = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sel         = SW'($urandom_range(0, 3));
      in_valid_s  = N'($urandom);
      in_valid_r  = N'($urandom);
      in_data_s   = $urandom;
      in_data_r   = $urandom;
      out_ready_s = ($urandom_range(0, 3) != 0);
      out_ready_r = ($urandom_range(0, 3) != 0);
      #1;
      checks += 2;
      if (in_ready_s !== exp_rdy_s()) begin failures++; $display("FAIL rnd_rdy_s[%0d]: got %b want %b", c, in_ready_s, exp_rdy_s()); end
      if (in_ready_r !== exp_rdy_r()) begin failures++; $display("FAIL rnd_rdy_r[%0d]: got %b want %b", c, in_ready_r, exp_rdy_r()); end
      tick();
      checks += 2;
      if (out_valid_s !== ms_valid || out_data_s !== ms_data || int'(grant_idx_s) != ms_gidx) begin
        failures++;
        $display("FAIL rnd_out_s[%0d]: got %b/%h/%0d want %b/%h/%0d", c, out_valid_s, out_data_s, grant_idx_s, ms_valid, ms_data, ms_gidx);
      end
      if (out_valid_r !== mr_valid || out_data_r !== mr_data || int'(grant_idx_r) != mr_gidx) begin
        failures++;
        $display("FAIL rnd_out_r[%0d]: got %b/%h/%0d want %b/%h/%0d", c, out_valid_r, out_data_r, grant_idx_r, mr_valid, mr_data, mr_gidx);
      end
    end
    in_valid_s = '0; in_valid_r = '0; out_ready_s = 1'b1; out_ready_r = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    in_data_r = 32'hD4C3_B2A1; out_ready_r = 1'b1; in_valid_r = 4'b0010;
    tick();
    out_ready_r = 1'b0; in_valid_r = 4'b1111;
    tick();
    checks++;
    if (out_valid_r !== 1'b1 || grant_idx_r !== 2'd1) begin
      failures++; $display("FAIL mid_stall: got %b/%0d want 1/1", out_valid_r, grant_idx_r);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_r !== 4'b0000) begin failures++; $display("FAIL mid_rst_rdy: got %b want 0000", in_ready_r); end
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid_r !== 1'b0 || out_data_r !== 8'h00) begin
      failures++; $display("FAIL mid_rst_out: got %b/%h want 0/00", out_valid_r, out_data_r);
    end
    in_valid_r = 4'b1010; out_ready_r = 1'b1;
    #1;
    checks++;
    if (in_ready_r !== 4'b0010) begin failures++; $display("FAIL mid_first_rdy: got %b want 0010", in_ready_r); end
    tick();
    checks++;
    if (grant_idx_r !== 2'd1 || out_data_r !== 8'hB2) begin
      failures++; $display("FAIL mid_first_grant: got ch%0d %h want ch1 b2", grant_idx_r, out_data_r);
    end
    in_valid_r = '0;
    tick();
  endtask

  initial begin
    ms_valid = 1'b0; ms_data = '0; ms_gidx = 0;
    mr_valid = 1'b0; mr_data = '0; mr_gidx = 0; mr_ptr = 0;
    rst = 1'b1; sel = '0;
    in_data_s = '0; in_data_r = '0; in_valid_s = '0; in_valid_r = '0;
    out_ready_s = 1'b1; out_ready_r = 1'b1;
    test_reset();
    test_sel_basic();
    test_backpressure();
    test_rr_all();
    test_rr_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
